// File: rtl/alu_pipe.sv
// alu_pipe: two-stage signed ALU with persistent MAD accumulator.
// S1 holds the accepted op; S2 is the output register under valid/ready.
module alu_pipe #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64,
  parameter int OP_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         op_code,
  input  logic signed [IN_W-1:0]  alu_in1,
  input  logic signed [IN_W-1:0]  alu_in2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] alu_out,
  output logic                    acc_ovf
);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MAD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_CLR = OP_W'(4);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
  } s1_t;

  s1_t  s1;
  logic s1_valid;

  logic signed [OUT_W-1:0]  acc;
  logic signed [OUT_W-1:0]  a_x;
  logic signed [OUT_W-1:0]  b_x;
  logic signed [2*IN_W-1:0] prod_n;
  logic signed [OUT_W-1:0]  prod;
  logic signed [OUT_W-1:0]  sum;
  logic signed [OUT_W-1:0]  res;
  logic                     ovf;
  logic                     s2_free;
  logic                     exec;
  logic                     take;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign exec     = s1_valid && s2_free;
  assign take     = in_valid && in_ready;

  assign a_x    = OUT_W'($signed(s1.a));
  assign b_x    = OUT_W'($signed(s1.b));
  assign prod_n = (2*IN_W)'($signed(s1.a))
                * (2*IN_W)'($signed(s1.b));
  assign prod   = OUT_W'(prod_n);
  assign sum    = prod + acc;
  // Same-sign addends with a differing sum sign is a signed wrap.
  assign ovf    = (prod[OUT_W-1] == acc[OUT_W-1])
               && (sum[OUT_W-1] != prod[OUT_W-1]);

  always_comb begin
    res = '0;
    unique case (1'b1)
      (s1.op == OP_ADD): res = a_x + b_x;
      (s1.op == OP_SUB): res = a_x - b_x;
      (s1.op == OP_MUL): res = prod;
      (s1.op == OP_MAD): res = sum;
      default:           res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      if (take) begin
        s1       <= '{op: op_code, a: alu_in1, b: alu_in2};
        s1_valid <= 1'b1;
      end else if (exec) begin
        s1_valid <= 1'b0;
      end
      if (s2_free) begin
        out_valid <= s1_valid;
      end
      if (exec) begin
        alu_out <= res;
        if (s1.op == OP_MAD) begin
          acc     <= sum;
          acc_ovf <= acc_ovf | ovf;
        end else if (s1.op == OP_CLR) begin
          acc     <= '0;
          acc_ovf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] MUL = 3'd1;
  localparam logic [2:0] MAD = 3'd2;
  localparam logic [2:0] SUB = 3'd3;
  localparam logic [2:0] CLR = 3'd4;
  localparam logic [2:0] RSV = 3'd7;

  localparam logic [63:0] P = 64'h3FFF_FFFF_0000_0001;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [2:0]         op_code = '0;
  logic signed [31:0] alu_in1 = '0;
  logic signed [31:0] alu_in2 = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [63:0] alu_out;
  logic               acc_ovf;

  int checks = 0;
  int failures = 0;

  alu_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] op,
                     input int a, input int b);
    in_valid = 1'b1;
    op_code  = op;
    alu_in1  = a;
    alu_in2  = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({out_valid, alu_out, acc_ovf} !== 66'd0) begin
      failures++;
      $display("FAIL reset_outs: got v=%b out=%h ovf=%b want 0",
               out_valid, alu_out, acc_ovf);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    put(ADD, 7, -3);
    step();
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_latency: got v=%b want 0", out_valid);
    end
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd4}) begin
      failures++;
      $display("FAIL add: got v=%b out=%h want 4", out_valid, alu_out);
    end
    put(SUB, 5, 9);
    step();
    idle();
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
      failures++;
      $display("FAIL sub: got v=%b out=%h want -4", out_valid, alu_out);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_mul();
    put(MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    step();
    put(MUL, -2, 3);
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, P}) begin
      failures++;
      $display("FAIL mul_max: got %h want %h", alu_out, P);
    end
    idle();
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFA}) begin
      failures++;
      $display("FAIL mul_neg: got v=%b out=%h want -6",
               out_valid, alu_out);
    end
  endtask

  task automatic test_mad_chain();
    put(CLR, 0, 0);
    step();
    put(MAD, 2, 3);
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd0}) begin
      failures++;
      $display("FAIL clr_beat: got v=%b out=%h want 0", out_valid, alu_out);
    end
    put(MAD, 4, 5);
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd6}) begin
      failures++;
      $display("FAIL mad1: got v=%b out=%h want 6", out_valid, alu_out);
    end
    put(ADD, 1, 1);
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd26}) begin
      failures++;
      $display("FAIL mad2: got v=%b out=%h want 26", out_valid, alu_out);
    end
    put(MAD, -1, 10);
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd2}) begin
      failures++;
      $display("FAIL add_mid: got v=%b out=%h want 2", out_valid, alu_out);
    end
    put(RSV, 5, 5);
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd16}) begin
      failures++;
      $display("FAIL mad3: got v=%b out=%h want 16", out_valid, alu_out);
    end
    put(MAD, 1, 1);
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd0}) begin
      failures++;
      $display("FAIL reserved: got v=%b out=%h want 0", out_valid, alu_out);
    end
    idle();
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd17}) begin
      failures++;
      $display("FAIL rsv_acc: got v=%b out=%h want 17", out_valid, alu_out);
    end
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    put(CLR, 0, 0);
    step();
    out_ready = 1'b0;
    put(MAD, 2, 3);
    step();
    put(MAD, 4, 5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, out_valid, alu_out} !== {2'b01, 64'd0}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b out=%h want 0/1/0",
                 i, in_ready, out_valid, alu_out);
      end
      if (i < 4) step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got rdy=%b want 1", in_ready);
    end
    step();
    put(MAD, -1, 10);
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd6}) begin
      failures++;
      $display("FAIL stall_mad1: got v=%b out=%h want 6", out_valid, alu_out);
    end
    step();
    idle();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd26}) begin
      failures++;
      $display("FAIL stall_mad2: got v=%b out=%h want 26", out_valid, alu_out);
    end
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd16}) begin
      failures++;
      $display("FAIL stall_mad3: got v=%b out=%h want 16", out_valid, alu_out);
    end
    step();
  endtask

  task automatic test_ovf();
    logic [63:0] exp [4] = '{P, 2 * P, 3 * P, 4 * P};
    logic        eov [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    put(CLR, 0, 0);
    step();
    put(MAD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) put(CLR, 0, 0);
      step();
      checks++;
      if ({out_valid, alu_out, acc_ovf} !== {1'b1, exp[i], eov[i]}) begin
        failures++;
        $display("FAIL ovf_beat[%0d]: got out=%h ovf=%b want %h/%b",
                 i, alu_out, acc_ovf, exp[i], eov[i]);
      end
    end
    idle();
    step();
    checks++;
    if ({out_valid, alu_out, acc_ovf} !== {1'b1, 64'd0, 1'b0}) begin
      failures++;
      $display("FAIL ovf_clr: got v=%b out=%h ovf=%b want 1/0/0",
               out_valid, alu_out, acc_ovf);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    put(MAD, 5, 5);
    step();
    put(MAD, 2, 2);
    step();
    idle();
    checks++;
    if ({in_ready, out_valid, alu_out} !== {2'b01, 64'd25}) begin
      failures++;
      $display("FAIL pre_reset: got rdy=%b v=%b out=%h want 0/1/25",
               in_ready, out_valid, alu_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, alu_out, acc_ovf} !== 66'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%b out=%h ovf=%b want 0",
               out_valid, alu_out, acc_ovf);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL dropped_beat: got v=%b want 0", out_valid);
    end
    put(MAD, 1, 1);
    step();
    idle();
    step();
    checks++;
    if ({out_valid, alu_out} !== {1'b1, 64'd1}) begin
      failures++;
      $display("FAIL post_reset_mad: got v=%b out=%h want 1",
               out_valid, alu_out);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_mad_chain();
    test_stall();
    test_ovf();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
